// File: rtl/led_pkg.sv
// rtl/led_pkg.sv - shared mode encodings and LED width for the LED sequencer
// Purpose: one place for the LED width, the mode enum and the mode-advance order.
// Ports: none (package).
package led_pkg;

    localparam int LED_W = 5;

    typedef enum logic [1:0] {
        MODE_UP     = 2'd0,
        MODE_DOWN   = 2'd1,
        MODE_BOUNCE = 2'd2,
        MODE_HOLD   = 2'd3
    } mode_t;

    // A press advances UP -> DOWN -> BOUNCE -> HOLD -> UP.
    function automatic mode_t next_mode(input mode_t m);
        case (m)
            MODE_UP:     return MODE_DOWN;
            MODE_DOWN:   return MODE_BOUNCE;
            MODE_BOUNCE: return MODE_HOLD;
            default:     return MODE_UP;
        endcase
    endfunction

endpackage

// File: rtl/led_sequencer_if.sv
// rtl/led_sequencer_if.sv - bundle of the sequencer's button and display signals
// Purpose: groups btn/led/mode/tick for benches and integration wrappers.
// Ports: none; modport master drives btn and observes the outputs,
//        modport slave is the sequencer's view.
interface led_sequencer_if;
    import led_pkg::*;

    logic             btn;
    logic [LED_W-1:0] led;
    logic [1:0]       mode;
    logic             tick;

    modport master (output btn, input led, input mode, input tick);
    modport slave  (input btn, output led, output mode, output tick);

endinterface

// File: rtl/led_debounce.sv
// rtl/led_debounce.sv - button synchronizer, debouncer and rising-edge press detector
// Purpose: turns a raw asynchronous button into a single-cycle press pulse.
// Ports: clk   - clock
//        rst   - asynchronous active-high reset
//        din   - raw button, active-high
//        press - one-cycle pulse on each accepted 0->1 change
module led_debounce #(
    parameter int DEBOUNCE = 120000
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE + 1);

    logic          sync1;
    logic          sync2;
    logic          level;
    logic [CW-1:0] cnt;

    // The counter runs only while the synced input disagrees with the accepted
    // level; the DEBOUNCE-th disagreeing cycle commits the new level. press is
    // registered alongside the level so it rises on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            level <= 1'b0;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
            press <= 1'b0;
            if (sync2 != level) begin
                if (cnt == CW'(DEBOUNCE - 1)) begin
                    level <= sync2;
                    cnt   <= '0;
                    press <= sync2;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/led_sequencer.sv
// rtl/led_sequencer.sv - button-driven LED pattern sequencer with prescaled stepping
// Purpose: prescaler, mode FSM and LED datapath; button handling is in led_debounce.
// Ports: clk  - clock
//        rst  - asynchronous active-high reset
//        btn  - raw push-button, active-high
//        led  - registered LED pattern
//        mode - current mode (0 UP, 1 DOWN, 2 BOUNCE, 3 HOLD)
//        tick - one-cycle step strobe
module led_sequencer
    import led_pkg::*;
#(
    parameter int PRESCALE = 1500000,
    parameter int DEBOUNCE = 120000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn,
    output logic [LED_W-1:0] led,
    output logic [1:0]       mode,
    output logic             tick
);

    localparam int PW = $clog2(PRESCALE + 1);

    mode_t         state;
    logic          dir_left;
    logic          press;
    logic [PW-1:0] pcnt;

    assign mode = state;

    led_debounce #(
        .DEBOUNCE(DEBOUNCE)
    ) u_debounce (
        .clk   (clk),
        .rst   (rst),
        .din   (btn),
        .press (press)
    );

    // tick is registered, so the step it requests is applied on the edge
    // where tick is seen high. A press on that same edge restarts the
    // prescaler and takes precedence, discarding the pending step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt     <= '0;
            tick     <= 1'b0;
            led      <= '0;
            state    <= MODE_UP;
            dir_left <= 1'b1;
        end else if (press) begin
            pcnt  <= '0;
            tick  <= 1'b0;
            state <= next_mode(state);
            case (next_mode(state))
                MODE_UP:   led <= '0;
                MODE_DOWN: led <= '1;
                MODE_BOUNCE: begin
                    led      <= LED_W'(1);
                    dir_left <= 1'b1;
                end
                default: ;
            endcase
        end else begin
            if (pcnt == PW'(PRESCALE - 1)) begin
                pcnt <= '0;
                tick <= 1'b1;
            end else begin
                pcnt <= pcnt + PW'(1);
                tick <= 1'b0;
            end
            if (tick) begin
                case (state)
                    MODE_UP:   led <= led + LED_W'(1);
                    MODE_DOWN: led <= led - LED_W'(1);
                    MODE_BOUNCE: begin
                        // Reverse at either end so the bit never falls off.
                        if (led[LED_W-1]) begin
                            led      <= led >> 1;
                            dir_left <= 1'b0;
                        end else if (led[0]) begin
                            led      <= led << 1;
                            dir_left <= 1'b1;
                        end else if (dir_left) begin
                            led <= led << 1;
                        end else begin
                            led <= led >> 1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_led_sequencer.sv
// tb/tb_led_sequencer.sv - self-checking bench for led_sequencer
module tb_led_sequencer;
    import led_pkg::*;

    localparam int P = 4;
    localparam int D = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    led_sequencer_if bus ();

    led_sequencer #(
        .PRESCALE (P),
        .DEBOUNCE (D)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .btn  (bus.btn),
        .led  (bus.led),
        .mode (bus.mode),
        .tick (bus.tick)
    );

    always #5 clk = ~clk;

    // Reference model: button history, run length of disagreement, mode as an
    // integer, UP/DOWN pattern as an integer mod 32, BOUNCE as a bit position
    // with a +1/-1 direction, and cycles elapsed since the last prescaler restart.
    int m_led, m_mode, m_k, m_pos, m_dir, m_run;
    bit m_tick, m_press, m_level, m_h1, m_h2;

    always @(posedge clk or posedge rst) begin
        bit np;
        np = 1'b0;
        if (rst) begin
            m_led = 0; m_mode = 0; m_k = 0; m_pos = 0; m_dir = 1; m_run = 0;
            m_tick = 0; m_press = 0; m_level = 0; m_h1 = 0; m_h2 = 0;
        end else begin
            if (m_h2 != m_level) begin
                m_run++;
                if (m_run == D) begin
                    m_level = m_h2;
                    m_run   = 0;
                    np      = m_h2;
                end
            end else begin
                m_run = 0;
            end
            if (m_press) begin
                m_mode = (m_mode + 1) % 4;
                case (m_mode)
                    0: m_led = 0;
                    1: m_led = 31;
                    2: begin m_pos = 0; m_dir = 1; m_led = 1; end
                    default: ;
                endcase
                m_k    = 0;
                m_tick = 0;
            end else begin
                if (m_tick) begin
                    case (m_mode)
                        0: m_led = (m_led + 1) % 32;
                        1: m_led = (m_led + 31) % 32;
                        2: begin
                            if (m_pos + m_dir > LED_W - 1 || m_pos + m_dir < 0) m_dir = -m_dir;
                            m_pos = m_pos + m_dir;
                            m_led = 1 << m_pos;
                        end
                        default: ;
                    endcase
                end
                m_k++;
                m_tick = (m_k % P == 0);
            end
            m_press = np;
            m_h2    = m_h1;
            m_h1    = bus.btn;
        end
    end

    task automatic test_reset();
        bus.btn = 1'b0;
        #2 rst = 1'b1;
        #1;
        checks++; if (bus.led !== 5'd0) begin errors++; $display("FAIL reset_led got %0d want 0", bus.led); end
        checks++; if (bus.mode !== 2'd0) begin errors++; $display("FAIL reset_mode got %0d want 0", bus.mode); end
        checks++; if (bus.tick !== 1'b0) begin errors++; $display("FAIL reset_tick got %0d want 0", bus.tick); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_free_run();
        for (int i = 1; i <= 33 * P; i++) begin
            @(negedge clk);
            checks++;
            if (bus.tick !== ((i % P) == 0)) begin
                errors++; $display("FAIL free_tick cyc %0d got %0d want %0d", i, bus.tick, (i % P) == 0);
            end
            checks++;
            if (bus.led !== 5'(((i - 1) / P) % 32)) begin
                errors++; $display("FAIL free_led cyc %0d got %0d want %0d", i, bus.led, ((i - 1) / P) % 32);
            end
        end
        checks++; if (bus.mode !== 2'd0) begin errors++; $display("FAIL free_mode got %0d want 0", bus.mode); end
    endtask

    task automatic test_glitch();
        bus.btn = 1'b1;
        repeat (2) @(negedge clk);
        bus.btn = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            checks++; if (bus.mode !== 2'd0) begin errors++; $display("FAIL glitch_mode cyc %0d got %0d want 0", i, bus.mode); end
        end
    endtask

    task automatic test_press_down();
        bus.btn = 1'b1;
        for (int i = 1; i <= 11; i++) begin
            @(negedge clk);
            if (i <= 5) begin
                checks++; if (bus.mode !== 2'd0) begin errors++; $display("FAIL press_early cyc %0d mode got %0d want 0", i, bus.mode); end
            end
            if (i == 6) begin
                checks++; if (bus.mode !== 2'd1) begin errors++; $display("FAIL press_mode got %0d want 1", bus.mode); end
                checks++; if (bus.led !== 5'b11111) begin errors++; $display("FAIL press_led got %b want 11111", bus.led); end
            end
            if (i == 10) begin
                checks++; if (bus.tick !== 1'b1) begin errors++; $display("FAIL press_tick got %0d want 1", bus.tick); end
            end
            if (i == 11) begin
                checks++; if (bus.led !== 5'b11110) begin errors++; $display("FAIL down_step got %b want 11110", bus.led); end
            end
        end
        bus.btn = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_bounce_seq();
        logic [LED_W-1:0] exp_seq [8];
        bit seen;
        exp_seq = '{5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b01000, 5'b00100, 5'b00010, 5'b00001};
        bus.btn = 1'b1;
        repeat (6) @(negedge clk);
        bus.btn = 1'b0;
        checks++; if (bus.mode !== 2'd2) begin errors++; $display("FAIL bounce_mode got %0d want 2", bus.mode); end
        checks++; if (bus.led !== 5'b00001) begin errors++; $display("FAIL bounce_entry got %b want 00001", bus.led); end
        for (int j = 0; j < 8; j++) begin
            seen = 1'b0;
            for (int t = 0; t < 20 && !seen; t++) begin
                @(negedge clk);
                seen = bus.tick;
            end
            checks++;
            if (!seen) begin
                errors++; $display("FAIL bounce_tick_timeout step %0d got none want tick", j);
            end else begin
                @(negedge clk);
                checks++;
                if (bus.led !== exp_seq[j]) begin errors++; $display("FAIL bounce_step %0d got %b want %b", j, bus.led, exp_seq[j]); end
            end
        end
    endtask

    task automatic test_collision();
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        repeat (27) @(negedge clk);
        bus.btn = 1'b1;
        repeat (5) @(negedge clk);
        checks++; if (bus.tick !== 1'b1) begin errors++; $display("FAIL coll_tick got %0d want 1", bus.tick); end
        checks++; if (bus.led !== 5'd7) begin errors++; $display("FAIL coll_led_before got %0d want 7", bus.led); end
        @(negedge clk);
        checks++; if (bus.mode !== 2'd1) begin errors++; $display("FAIL coll_mode got %0d want 1", bus.mode); end
        checks++; if (bus.led !== 5'd31) begin errors++; $display("FAIL coll_led got %0d want 31", bus.led); end
        repeat (3) @(negedge clk);
        checks++; if (bus.tick !== 1'b0) begin errors++; $display("FAIL coll_restart_early got %0d want 0", bus.tick); end
        @(negedge clk);
        checks++; if (bus.tick !== 1'b1) begin errors++; $display("FAIL coll_restart_tick got %0d want 1", bus.tick); end
        bus.btn = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        repeat (2) begin
            bus.btn = 1'b1;
            repeat (8) @(negedge clk);
            bus.btn = 1'b0;
            repeat (8) @(negedge clk);
        end
        checks++; if (bus.mode !== 2'd3) begin errors++; $display("FAIL hold_mode got %0d want 3", bus.mode); end
        bus.btn = 1'b1;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        bus.btn = 1'b0;
        #1;
        checks++; if (bus.led !== 5'd0) begin errors++; $display("FAIL mid_rst_led got %0d want 0", bus.led); end
        checks++; if (bus.mode !== 2'd0) begin errors++; $display("FAIL mid_rst_mode got %0d want 0", bus.mode); end
        @(negedge clk) rst = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (i <= 4) begin
                checks++; if (bus.tick !== (i == 4)) begin errors++; $display("FAIL mid_rst_tick cyc %0d got %0d want %0d", i, bus.tick, i == 4); end
            end
            checks++; if (bus.mode !== 2'd0) begin errors++; $display("FAIL mid_rst_nopress cyc %0d got %0d want 0", i, bus.mode); end
        end
    endtask

    task automatic test_btn_through_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.btn = 1'b1;
        @(negedge clk) rst = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            checks++;
            if (bus.mode !== ((i == 6) ? 2'd1 : 2'd0)) begin
                errors++; $display("FAIL held_btn cyc %0d got %0d want %0d", i, bus.mode, (i == 6) ? 1 : 0);
            end
        end
        bus.btn = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic test_random();
        int hold;
        hold = 0;
        for (int i = 0; i < 800; i++) begin
            if (hold == 0) begin
                bus.btn = $urandom_range(0, 1);
                hold    = $urandom_range(1, 9);
            end
            hold--;
            @(negedge clk);
            checks++; if (bus.led !== 5'(m_led)) begin errors++; $display("FAIL rand_led cyc %0d got %0d want %0d", i, bus.led, m_led); end
            checks++; if (bus.mode !== 2'(m_mode)) begin errors++; $display("FAIL rand_mode cyc %0d got %0d want %0d", i, bus.mode, m_mode); end
            checks++; if (bus.tick !== m_tick) begin errors++; $display("FAIL rand_tick cyc %0d got %0d want %0d", i, bus.tick, m_tick); end
        end
        bus.btn = 1'b0;
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_glitch();
        test_press_down();
        test_bounce_seq();
        test_collision();
        test_reset_mid();
        test_btn_through_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
